// File: rtl/tt_pad_pkg.sv
// tt_pad_ctrl shared types: pad modes, FSM states, cfg layout.
// Optional readback is enabled with TT_PAD_CTRL_READBACK_EN.
package tt_pad_pkg;

   typedef enum logic [1:0] {
      PAD_IN    = 2'b00,
      PAD_OUT   = 2'b01,
      PAD_BIDIR = 2'b10,
      PAD_OFF   = 2'b11
   } pad_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TURN  = 2'd1,
      APPLY = 2'd2
   } pad_state_e;

   localparam int CFG_W       = 6;
   localparam int CFG_PU      = 0;
   localparam int CFG_PD      = 1;
   localparam int CFG_CS      = 2;
   localparam int CFG_SL      = 3;
   localparam int CFG_MODE_LO = 4;
   localparam int CFG_MODE_HI = 5;

   localparam logic [CFG_W-1:0] CFG_RST = '0;

endpackage

// File: rtl/tt_pad_sync.sv
// Single-bit multi-flop synchroniser for an asynchronous pad input.
// Depth set by STAGES (2..3), all flops cleared on reset.
module tt_pad_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // shift the raw pad value through the synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tt_pad_ctrl.sv
// Per-pad config and control for tt_cell_macro_2 IO cells, with OE turnaround.
// Define TT_PAD_CTRL_READBACK_EN to add rd_idx/rd_data config readback.
module tt_pad_ctrl
   import tt_pad_pkg::*;
#(
   parameter  int NUM_PADS    = 8,
   parameter  int TURN_CYCLES = 2,
   parameter  int SYNC_STAGES = 2,
   localparam int IW          = $clog2(NUM_PADS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [IW-1:0]       cfg_idx,
   input  logic [5:0]          cfg_data,
   input  logic [NUM_PADS-1:0] core_out,
   input  logic [NUM_PADS-1:0] core_oe,
   output logic [NUM_PADS-1:0] core_in,
   output logic                busy,
   output logic [NUM_PADS-1:0] hsig_A,
   output logic [NUM_PADS-1:0] hsig_OE,
   output logic [NUM_PADS-1:0] hsig_IE,
   output logic [NUM_PADS-1:0] hsig_SL,
   output logic [NUM_PADS-1:0] hsig_CS,
   output logic [NUM_PADS-1:0] hsig_PD,
   output logic [NUM_PADS-1:0] hsig_PU,
   input  logic [NUM_PADS-1:0] hsig_Y,
`ifdef TT_PAD_CTRL_READBACK_EN
   input  logic [IW-1:0]       rd_idx,
   output logic [5:0]          rd_data,
`endif
   output logic                hclk_PD,
   output logic                hclk_PU
);

   logic [CFG_W-1:0]    cfg_q [NUM_PADS];
   logic [CFG_W-1:0]    cfg_d [NUM_PADS];
   pad_state_e          state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [IW-1:0]       pidx_q, pidx_d;
   logic [CFG_W-1:0]    pdata_q, pdata_d;
   logic                clk_pd_q, clk_pd_d;
   logic                clk_pu_q, clk_pu_d;
   logic [NUM_PADS-1:0] a_q, a_d;
   logic [NUM_PADS-1:0] oe_q, oe_d;
   logic [NUM_PADS-1:0] ie_q, ie_d;
   logic                accept, is_pad, is_clk;
   logic                force_oe;
   logic [1:0]          old_mode, new_mode;

   assign cfg_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign accept    = cfg_valid && cfg_ready;
   assign is_pad    = (cfg_idx < IW'(NUM_PADS));
   assign is_clk    = (cfg_idx == IW'(NUM_PADS));
   assign new_mode  = cfg_data[CFG_MODE_HI:CFG_MODE_LO];

   // current mode of the pad addressed by the incoming write
   always_comb begin
      old_mode = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (cfg_idx == IW'(i)) old_mode = cfg_q[i][CFG_MODE_HI:CFG_MODE_LO];
      end
   end

   // write FSM: clock-pad writes land at once, pad writes go via TURN/APPLY
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pidx_d   = pidx_q;
      pdata_d  = pdata_q;
      clk_pd_d = clk_pd_q;
      clk_pu_d = clk_pu_q;
      unique case (state_q)
         IDLE: begin
            if (accept && is_clk) begin
               clk_pd_d = cfg_data[CFG_PD];
               clk_pu_d = cfg_data[CFG_PU];
            end else if (accept && is_pad) begin
               pidx_d  = cfg_idx;
               pdata_d = cfg_data;
               if ((new_mode != old_mode) &&
                   (new_mode == PAD_OUT || new_mode == PAD_BIDIR)) begin
                  state_d = TURN;
                  cnt_d   = 4'(TURN_CYCLES - 1);
               end else begin
                  state_d = APPLY;
               end
            end
         end
         TURN: begin
            if (cnt_q == '0) state_d = APPLY;
            else             cnt_d   = cnt_q - 4'd1;
         end
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // config array with the pending write merged in during APPLY
   always_comb begin
      for (int i = 0; i < NUM_PADS; i++) begin
         cfg_d[i] = cfg_q[i];
         if (state_q == APPLY && pidx_q == IW'(i)) cfg_d[i] = pdata_q;
      end
   end

   // target pad OE stays low from accept through the end of APPLY
   assign force_oe = (state_d == TURN) || (state_q == TURN);

   // per-pad mode decode into next cell A/OE/IE values
   always_comb begin
      for (int i = 0; i < NUM_PADS; i++) begin
         a_d[i]  = 1'b0;
         oe_d[i] = 1'b0;
         ie_d[i] = 1'b1;
         unique case (pad_mode_e'(cfg_d[i][CFG_MODE_HI:CFG_MODE_LO]))
            PAD_IN:    ;
            PAD_OUT:   begin oe_d[i] = 1'b1; a_d[i] = core_out[i]; end
            PAD_BIDIR: begin oe_d[i] = core_oe[i]; a_d[i] = core_out[i]; end
            PAD_OFF:   ie_d[i] = 1'b0;
            default:   ;
         endcase
         if (force_oe && pidx_d == IW'(i)) oe_d[i] = 1'b0;
      end
   end

   // FSM state, turnaround counter, pending write and clock-pad pulls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         pidx_q   <= '0;
         pdata_q  <= CFG_RST;
         clk_pd_q <= 1'b0;
         clk_pu_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pidx_q   <= pidx_d;
         pdata_q  <= pdata_d;
         clk_pd_q <= clk_pd_d;
         clk_pu_q <= clk_pu_d;
      end
   end

   // stored per-pad configuration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PADS; i++) cfg_q[i] <= CFG_RST;
      end else begin
         for (int i = 0; i < NUM_PADS; i++) cfg_q[i] <= cfg_d[i];
      end
   end

   // registered cell drive pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q  <= '0;
         oe_q <= '0;
         ie_q <= '1;
      end else begin
         a_q  <= a_d;
         oe_q <= oe_d;
         ie_q <= ie_d;
      end
   end

   // static pad attributes straight from the config registers
   always_comb begin
      for (int i = 0; i < NUM_PADS; i++) begin
         hsig_SL[i] = cfg_q[i][CFG_SL];
         hsig_CS[i] = cfg_q[i][CFG_CS];
         hsig_PD[i] = cfg_q[i][CFG_PD];
         hsig_PU[i] = cfg_q[i][CFG_PU];
      end
   end

   assign hsig_A  = a_q;
   assign hsig_OE = oe_q;
   assign hsig_IE = ie_q;
   assign hclk_PD = clk_pd_q;
   assign hclk_PU = clk_pu_q;

   for (genvar g = 0; g < NUM_PADS; g++) begin : g_sync
      tt_pad_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d_i   (hsig_Y[g]),
         .q_o   (core_in[g])
      );
   end

`ifdef TT_PAD_CTRL_READBACK_EN
   logic [5:0] rd_q, rd_d;

   // select stored config for readback; unknown index reads 0
   always_comb begin
      rd_d = '0;
      for (int i = 0; i < NUM_PADS; i++) begin
         if (rd_idx == IW'(i)) rd_d = cfg_q[i];
      end
      if (rd_idx == IW'(NUM_PADS)) rd_d = {4'b0, clk_pd_q, clk_pu_q};
   end

   // one-cycle registered readback
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= rd_d;
   end

   assign rd_data = rd_q;
`endif

endmodule

// File: tb/tb_tt_pad_ctrl.sv
// Self-checking bench for tt_pad_ctrl: vector table, corner sequences,
// and random traffic against a cycle-level behavioural model.
module tb_tt_pad_ctrl;

   localparam int N    = 8;
   localparam int TURN = 2;
   localparam int SYNC = 2;

   logic       clk, rst_n;
   logic       cfg_valid, cfg_ready;
   logic [3:0] cfg_idx;
   logic [5:0] cfg_data;
   logic [N-1:0] core_out, core_oe, core_in;
   logic       busy;
   logic [N-1:0] hsig_A, hsig_OE, hsig_IE, hsig_SL, hsig_CS;
   logic [N-1:0] hsig_PD, hsig_PU, hsig_Y;
   logic       hclk_PD, hclk_PU;
`ifdef TT_PAD_CTRL_READBACK_EN
   logic [3:0] rd_idx;
   logic [5:0] rd_data;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   tt_pad_ctrl #(.NUM_PADS(N), .TURN_CYCLES(TURN), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_idx(cfg_idx), .cfg_data(cfg_data),
      .core_out(core_out), .core_oe(core_oe), .core_in(core_in),
      .busy(busy),
      .hsig_A(hsig_A), .hsig_OE(hsig_OE), .hsig_IE(hsig_IE),
      .hsig_SL(hsig_SL), .hsig_CS(hsig_CS),
      .hsig_PD(hsig_PD), .hsig_PU(hsig_PU), .hsig_Y(hsig_Y),
`ifdef TT_PAD_CTRL_READBACK_EN
      .rd_idx(rd_idx), .rd_data(rd_data),
`endif
      .hclk_PD(hclk_PD), .hclk_PU(hclk_PU)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       v;
      logic [3:0] idx;
      logic [5:0] data;
      logic [7:0] co, coe;
      logic [7:0] oe, a, ie, pu;
      logic       busy;
   } vec_t;

   localparam int NV = 16;
   vec_t tbl [NV];

   // behavioural model state
   logic [5:0] m_cfg [N];
   logic [1:0] m_clk;
   int         rem;
   int         p_idx;
   logic [5:0] p_data;
   bit         p_turn;
   logic [N-1:0] yq[$];
   logic [N-1:0] e_oe, e_a, e_ie, e_sl, e_cs, e_pd, e_pu, e_in;

   // advance the model by one clock edge using the inputs held at that edge
   task automatic model_edge();
      bit rdy;
      logic [1:0] md, nm;
      rdy = (rem == 0);
      if (rem == 1) m_cfg[p_idx] = p_data;
      if (rem > 0) rem--;
      if (rdy && cfg_valid) begin
         if (int'(cfg_idx) == N) begin
            m_clk = cfg_data[1:0];
         end else if (int'(cfg_idx) < N) begin
            p_idx  = int'(cfg_idx);
            p_data = cfg_data;
            nm     = cfg_data[5:4];
            p_turn = (nm != m_cfg[p_idx][5:4]) && (nm == 2'b01 || nm == 2'b10);
            rem    = p_turn ? TURN + 1 : 1;
         end
      end
      for (int i = 0; i < N; i++) begin
         md = m_cfg[i][5:4];
         e_oe[i] = (md == 2'b01) ? 1'b1 : (md == 2'b10) ? core_oe[i] : 1'b0;
         e_a[i]  = (md == 2'b01 || md == 2'b10) ? core_out[i] : 1'b0;
         e_ie[i] = (md != 2'b11);
         e_sl[i] = m_cfg[i][3];
         e_cs[i] = m_cfg[i][2];
         e_pd[i] = m_cfg[i][1];
         e_pu[i] = m_cfg[i][0];
      end
      if (rem > 0 && p_turn) e_oe[p_idx] = 1'b0;
      yq.push_front(hsig_Y);
      if (yq.size() > SYNC) void'(yq.pop_back());
      e_in = (yq.size() == SYNC) ? yq[SYNC-1] : '0;
   endtask

   initial begin
      rst_n = 1'b0; cfg_valid = 1'b0; cfg_idx = '0; cfg_data = '0;
      core_out = '0; core_oe = '0; hsig_Y = '0;
`ifdef TT_PAD_CTRL_READBACK_EN
      rd_idx = '0;
`endif
      tbl[0]  = '{1'b1, 4'd3, 6'h10, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};
      tbl[1]  = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};
      tbl[2]  = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};
      tbl[3]  = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h00, 8'h08, 8'h08, 8'hFF, 8'h00, 1'b0};
      tbl[4]  = '{1'b1, 4'd3, 6'h00, 8'h08, 8'h00, 8'h08, 8'h08, 8'hFF, 8'h00, 1'b1};
      tbl[5]  = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0};
      tbl[6]  = '{1'b1, 4'd0, 6'h20, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};
      tbl[7]  = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};
      tbl[8]  = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h01, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};
      tbl[9]  = '{1'b0, 4'd0, 6'h00, 8'h09, 8'h00, 8'h00, 8'h01, 8'hFF, 8'h00, 1'b0};
      tbl[10] = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h01, 8'h01, 8'h00, 8'hFF, 8'h00, 1'b0};
      tbl[11] = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0};
      tbl[12] = '{1'b1, 4'd3, 6'h30, 8'h08, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};
      tbl[13] = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'hF7, 8'h00, 1'b0};
      tbl[14] = '{1'b1, 4'd2, 6'h03, 8'h08, 8'h00, 8'h00, 8'h00, 8'hF7, 8'h00, 1'b1};
      tbl[15] = '{1'b0, 4'd0, 6'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'hF7, 8'h04, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_oe", 32'(hsig_OE), 32'h00);
      chk("rst_ie", 32'(hsig_IE), 32'hFF);
      chk("rst_pdpu", 32'({hsig_PD, hsig_PU, hclk_PD, hclk_PU}), 32'h0);
      chk("rst_ready", 32'({busy, cfg_ready}), 32'h1);
      chk("rst_core_in", 32'(core_in), 32'h0);

      for (int k = 0; k < NV; k++) begin
         cfg_valid = tbl[k].v;
         cfg_idx   = tbl[k].idx;
         cfg_data  = tbl[k].data;
         core_out  = tbl[k].co;
         core_oe   = tbl[k].coe;
         step();
         chk($sformatf("vec%0d_oe", k), 32'(hsig_OE), 32'(tbl[k].oe));
         chk($sformatf("vec%0d_a", k), 32'(hsig_A), 32'(tbl[k].a));
         chk($sformatf("vec%0d_ie", k), 32'(hsig_IE), 32'(tbl[k].ie));
         chk($sformatf("vec%0d_pu", k), 32'(hsig_PU), 32'(tbl[k].pu));
         chk($sformatf("vec%0d_busy", k), 32'({busy, cfg_ready}),
             32'({tbl[k].busy, ~tbl[k].busy}));
      end
      cfg_valid = 1'b0;
      core_out  = '0;
      core_oe   = '0;

      // clock pad: PD/PU from data[1:0] on the next cycle
      cfg_valid = 1'b1; cfg_idx = 4'd8; cfg_data = 6'b110110;
      step();
      cfg_valid = 1'b0;
      chk("clk_pad", 32'({hclk_PD, hclk_PU}), 32'h2);
      chk("clk_pad_busy", 32'(busy), 32'h0);

      // out-of-range index is swallowed
      cfg_valid = 1'b1; cfg_idx = 4'd9; cfg_data = 6'b010011;
      step();
      cfg_valid = 1'b0;
      step();
      chk("bad_idx_oe", 32'(hsig_OE), 32'h00);
      chk("bad_idx_ie", 32'(hsig_IE), 32'hF7);
      chk("bad_idx_pdpu", 32'({hsig_PD, hsig_PU}), 32'h0404);
      chk("bad_idx_clk", 32'({hclk_PD, hclk_PU, busy}), 32'h4);

      // hsig_Y pulse through the synchroniser
      hsig_Y = 8'h20;
      step();
      chk("sync_stage1", 32'(core_in), 32'h00);
      hsig_Y = 8'h00;
      step();
      chk("sync_stage2", 32'(core_in), 32'h20);
      step();
      chk("sync_fall", 32'(core_in), 32'h00);

      // back-to-back writes with cfg_valid held
      cfg_valid = 1'b1; cfg_idx = 4'd1; cfg_data = 6'h10;
      step();
      chk("b2b_first_busy", 32'(busy), 32'h1);
      cfg_idx = 4'd2;
      repeat (3) step();
      chk("b2b_gap", 32'({busy, hsig_OE[1]}), 32'h1);
      step();
      chk("b2b_second_busy", 32'(busy), 32'h1);
      cfg_valid = 1'b0;
      for (int k = 0; k < 20 && busy; k++) step();
      chk("b2b_timeout", 32'(busy), 32'h0);
      chk("b2b_oe", 32'(hsig_OE), 32'h06);

      // reset during TURN aborts the write
      cfg_valid = 1'b1; cfg_idx = 4'd4; cfg_data = 6'h10;
      step();
      cfg_valid = 1'b0;
      step();
      chk("mid_turn_busy", 32'(busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_oe_ie", 32'({hsig_OE, hsig_IE}), 32'h00FF);
      chk("arst_pdpu", 32'({hsig_PD, hsig_PU, hclk_PD, hclk_PU}), 32'h0);
      chk("arst_ready", 32'({busy, cfg_ready}), 32'h1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) step();
      chk("arst_aborted", 32'({hsig_OE, busy}), 32'h0);

      // random traffic against the model, starting from reset state
      for (int i = 0; i < N; i++) m_cfg[i] = '0;
      m_clk = '0; rem = 0; p_idx = 0; p_data = '0; p_turn = 1'b0;
      yq.delete();
      for (int c = 0; c < 600; c++) begin
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_idx   = 4'($urandom_range(0, 10));
         cfg_data  = 6'($urandom);
         core_out  = N'($urandom);
         core_oe   = N'($urandom);
         hsig_Y    = N'($urandom);
         @(posedge clk);
         model_edge();
         #1;
         chk("rnd_oe", 32'(hsig_OE), 32'(e_oe));
         chk("rnd_a", 32'(hsig_A), 32'(e_a));
         chk("rnd_ie", 32'(hsig_IE), 32'(e_ie));
         chk("rnd_slcs", 32'({hsig_SL, hsig_CS}), 32'({e_sl, e_cs}));
         chk("rnd_pdpu", 32'({hsig_PD, hsig_PU}), 32'({e_pd, e_pu}));
         chk("rnd_clk", 32'({hclk_PD, hclk_PU}), 32'(m_clk));
         chk("rnd_busy", 32'({busy, cfg_ready}),
             32'({rem > 0, rem == 0}));
         chk("rnd_core_in", 32'(core_in), 32'(e_in));
      end
      cfg_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tt_pad_ctrl.md
Name: tt_pad_ctrl

Overview:
- Per-pad control stage directly upstream of the tt_cell_macro_2 IO cells.
- Holds a configuration register for each of NUM_PADS signal pads and the one clock pad.
- Drives every hsig_*/hclk_* control pin of the cells; synchronises each hsig_Y back into the core clock domain.
- On a direction change, runs a timed output-enable turnaround so two drivers never fight on the pad.

Parameters:
- NUM_PADS, 8, number of signal pads served; one IO cell per pad.
- TURN_CYCLES, 2, cycles OE is held low before a new output config takes effect; legal range 1..15.
- SYNC_STAGES, 2, flops in each hsig_Y synchroniser; legal range 2..3.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  block can accept a config write.
- cfg_idx  in  $clog2(NUM_PADS+1)  target pad; value NUM_PADS selects the clock pad.
- cfg_data  in  6  {mode[1:0], SL, CS, PD, PU}.
- core_out  in  NUM_PADS  core output data.
- core_oe  in  NUM_PADS  core OE, used in mode 10 only.
- core_in  out  NUM_PADS  synchronised pad input.
- busy  out  1  turnaround in progress.
- hsig_A  out  NUM_PADS  to cell A.
- hsig_OE  out  NUM_PADS  to cell OE.
- hsig_IE  out  NUM_PADS  to cell IE.
- hsig_SL  out  NUM_PADS  to cell SL.
- hsig_CS  out  NUM_PADS  to cell CS.
- hsig_PD  out  NUM_PADS  to cell PD.
- hsig_PU  out  NUM_PADS  to cell PU.
- hsig_Y  in  NUM_PADS  from cell Y; asynchronous to clk.
- hclk_PD  out  1  clock pad pull-down.
- hclk_PU  out  1  clock pad pull-up.

Behaviour:
- Reset is asynchronous and active-low on rst_n; single clock clk.
- Reset values:
  - all pad configs are mode 00, SL=CS=PD=PU=0;
  - hsig_OE=0, hsig_IE=1, hsig_A=0, hclk_PD=hclk_PU=0;
  - core_in=0, all synchroniser flops=0, busy=0, cfg_ready=1, state IDLE.
- Mode decode per pad, registered outputs, 1-cycle latency from core_out/core_oe to hsig_A/hsig_OE:
  - 00 input: OE=0, IE=1;
  - 01 output: OE=1, IE=1, A=core_out;
  - 10 bidir: OE=core_oe, IE=1;
  - 11 off: OE=0, IE=0, A=0.
- SL, CS, PD, PU pass straight from the config register to the cell pins.
- Handshake: a write is accepted when cfg_valid && cfg_ready. cfg_ready = (state==IDLE). cfg_valid may stay high across busy cycles.
- A write with cfg_idx > NUM_PADS is accepted and discarded; no state change.
- A write with cfg_idx == NUM_PADS updates hclk_PD/PU from cfg_data[1:0] the next cycle; mode, SL and CS are ignored.
- FSM:
  - IDLE -> APPLY when an accepted write does not change the mode, or the new mode is 00 or 11.
  - IDLE -> TURN when the mode changes and the new mode is 01 or 10.
  - TURN: the target pad's OE is forced 0 and a counter is loaded with TURN_CYCLES-1. Move to APPLY when the counter reaches 0.
  - APPLY: write the config register, return to IDLE. busy=1 in TURN and APPLY.
- A write leaving an output mode (to 00/11) drops OE on the cycle after APPLY, with no turnaround.
- Other pads keep operating normally during TURN.
- Reset asserted mid-TURN aborts the write; all pads return to reset config.
- core_in[i] is hsig_Y[i] after SYNC_STAGES flops. It is sampled even when IE=0; the cell returns 0 in that case.

Optional Feature:
- Macro: TT_PAD_CTRL_READBACK_EN.
- When defined:
  - adds input rd_idx and output rd_data[5:0];
  - rd_data is the stored config of rd_idx, registered with 1 cycle latency;
  - rd_data=0 for rd_idx > NUM_PADS;
  - for the clock pad, rd_data = {4'b0, PD, PU}.
- When undefined, these ports are absent and there is no readback logic.

Decomposition:
- Package tt_pad_pkg holds:
  - mode enum (PAD_IN, PAD_OUT, PAD_BIDIR, PAD_OFF);
  - FSM state enum (IDLE, TURN, APPLY);
  - cfg field bit positions;
  - reset config constant.
- One sub-module, tt_pad_sync: an SYNC_STAGES-deep synchroniser with async reset, instantiated per pad.

Test Plan:
- Reset: after reset release, all hsig_OE=0, hsig_IE=1, PD/PU=0, cfg_ready=1.
- Pad 3 input -> output:
  - stimulus: write idx=3, data=6'b01_0000 with core_out[3]=1;
  - OE[3]=0 for 2 cycles while busy=1;
  - then OE[3]=1 and A[3]=1; cfg_ready returns high.
- Output -> input: write idx=3 data=0; OE[3]=0 one cycle after APPLY, no TURN state entered.
- Bidir: pad 0 in mode 10; toggling core_oe[0] 0->1 makes hsig_OE[0] follow 1 cycle later.
- Back-to-back writes: cfg_valid held with idx=1 then idx=2, both to mode 01; second is accepted only after the first's APPLY; both pads end at OE=1.
- Clock pad and bad index:
  - idx=NUM_PADS with data bits[1:0]=2'b10 -> hclk_PD=1, hclk_PU=0;
  - idx=NUM_PADS+1 -> no output change;
  - hsig_Y[5] pulse -> core_in[5] rises 2 cycles later;
  - rst_n low mid-TURN -> all outputs return to reset values immediately.
